// File: rtl/axi_rom_responder.sv
// AXI4 read-only responder that serves one burst at a time from a word array.
// Define AXI_ROM_RANGE_CHECK_EN to answer out-of-range beats with SLVERR.
module axi_rom_responder #(
  parameter int          ID_WIDTH   = 13,
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 64,
  parameter int          MEM_WORDS  = 1024,
  parameter logic [63:0] BASE_ADDR  = 64'h0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ID_WIDTH-1:0]          s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [ID_WIDTH-1:0]          s_axi_rid,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0]        mem_wdata
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  ready_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  ar_hs;
  logic                  r_hs;
  logic                  last;
  logic                  load;
  logic                  wrap_ok;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [ADDR_WIDTH-1:0] off;
  logic [AW-1:0]         ld_idx;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [1:0]            ld_resp;

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid && s_axi_rready;
  assign last  = (cnt_q == len_q);
  assign load  = ar_hs || (r_hs && !last);
  assign base  = ADDR_WIDTH'(BASE_ADDR);

  always_comb begin
    step    = ADDR_WIDTH'(1) << size_q;
    wmask   = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q)
              - ADDR_WIDTH'(1);
    wrap_ok = (burst_q == 2'b10) &&
              (len_q == 8'd1 || len_q == 8'd3 ||
               len_q == 8'd7 || len_q == 8'd15);
    addr_nx = addr_q + step;
    unique case (1'b1)
      (burst_q == 2'b00): addr_nx = addr_q;
      wrap_ok:            addr_nx = (addr_q & ~wmask) |
                                    ((addr_q + step) & wmask);
      default:            addr_nx = addr_q + step;
    endcase
  end

  // In IDLE the beat address comes straight from the AR channel
  assign ld_addr = (state == IDLE) ? s_axi_araddr : addr_nx;
  assign off     = ld_addr - base;
  assign ld_idx  = AW'(off >> 3);

`ifdef AXI_ROM_RANGE_CHECK_EN
  logic in_range;
  assign in_range = (ld_addr >= base) && ((off >> (AW + 3)) == '0);
  assign ld_data  = in_range ? mem[ld_idx] : '0;
  assign ld_resp  = in_range ? 2'b00 : 2'b10;
`else
  assign ld_data  = mem[ld_idx];
  assign ld_resp  = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (ar_hs) state_nx = BURST;
      BURST:   if (r_hs && last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = ready_q;
    s_axi_rvalid  = (state == BURST);
    s_axi_rlast   = (state == BURST) && last;
    s_axi_rid     = id_q;
    s_axi_rdata   = rdata_q;
    s_axi_rresp   = rresp_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      ready_q <= (state_nx == IDLE);
      if (ar_hs) begin
        id_q    <= s_axi_arid;
        len_q   <= s_axi_arlen;
        size_q  <= s_axi_arsize;
        burst_q <= s_axi_arburst;
        cnt_q   <= '0;
      end else if (r_hs && !last) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (load) begin
        addr_q  <= ld_addr;
        rdata_q <= ld_data;
        rresp_q <= ld_resp;
      end
    end
  end

  // Storage is deliberately not reset so preloaded images survive
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: doc/axi_rom_responder.md
# axi_rom_responder

AXI4 read-channel responder (AR/R subordinate) serving 64-bit beats from an internal word array. It is the far end of the instruction-fetch initiator in `top`: it accepts one read burst at a time, returns `arlen+1` beats with the INCR, WRAP or FIXED addressing rule, and drives `rlast` on the final beat. A bench-side backdoor write port preloads program images. The block is used as the fetch-memory model in simulation benches and in small synthesized test harnesses.

## Interface
- `ID_WIDTH`, 13, AXI ID width.
- `ADDR_WIDTH`, 64, AXI address width.
- `DATA_WIDTH`, 64, beat width; fixed at 64, other values unsupported.
- `MEM_WORDS`, 1024, number of 64-bit words; must be a power of two.
- `BASE_ADDR`, 64'h0, byte address of word 0; 8-byte aligned.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `s_axi_arid`  in  ID_WIDTH  request ID.
- `s_axi_araddr`  in  ADDR_WIDTH  start byte address.
- `s_axi_arlen`  in  8  beats minus one.
- `s_axi_arsize`  in  3  log2 bytes per beat; 0..3 legal.
- `s_axi_arburst`  in  2  00 FIXED, 01 INCR, 10 WRAP; 11 is treated as INCR.
- `s_axi_arvalid`  in  1  address valid.
- `s_axi_arready`  out  1  address ready.
- `s_axi_rid`  out  ID_WIDTH  echoed ID.
- `s_axi_rdata`  out  64  full aligned word.
- `s_axi_rresp`  out  2  00 OKAY, 10 SLVERR.
- `s_axi_rlast`  out  1  final beat.
- `s_axi_rvalid`  out  1  beat valid.
- `s_axi_rready`  in  1  initiator ready.
- `mem_we`  in  1  backdoor write enable.
- `mem_waddr`  in  log2(MEM_WORDS)  backdoor word index.
- `mem_wdata`  in  64  backdoor data.

## Operation
- Two states: IDLE and BURST.
- **IDLE**
  - `arready`=1.
  - On `arvalid&&arready`, capture id, addr, len, size and burst; clear the beat counter.
  - Read `mem[idx(addr)]` into the `rdata` register.
  - Next state is BURST.
- **BURST**
  - `rvalid`=1.
  - `rlast` = (count==len).
  - On `rvalid&&rready` with `!rlast`: count+1, addr=next(addr), and load `rdata`/`rresp` for the next address.
  - On `rvalid&&rready` with `rlast`: go to IDLE.
- Beat address, with b = 1<<size:
  - FIXED: addr unchanged.
  - INCR: addr+b, 64-bit arithmetic, wraps modulo 2^64.
  - WRAP: W = (len+1)*b; next = (addr & ~(W-1)) | ((addr+b) & (W-1)).
  - WRAP with len not in {1,3,7,15} is treated as INCR.
- Word index: idx(a) = ((a-BASE_ADDR)>>3) mod MEM_WORDS.
  - `rdata` is always the full aligned word; the initiator selects lanes.
  - Sub-word sizes advance within the word.
- `rresp`=OKAY unless set by the range check (see Configuration).
- One outstanding burst only. `arvalid` in BURST is ignored, with `arready`=0.
- Backdoor write commits at the clk edge.
  - A write and a read of the same word at the same edge returns the old data.
  - `rdata` is registered, so it never changes while `rvalid&&!rready`.

## Timing
- Reset values: `arready`=0, `rvalid`=0, `rlast`=0, `rid`=0, `rdata`=0, `rresp`=00, state IDLE, counter 0.
- `arready` rises the first cycle after `reset` deasserts.
- AR handshake at edge N: beat 0 is visible (`rvalid`=1) in cycle N+1, and `arready`=0 from cycle N+1.
- With `rready` held at 1: one beat per cycle, and a burst of len L occupies L+1 cycles.
- Last handshake at edge M: in cycle M+1, `rvalid`=0, `rlast`=0 and `arready`=1. The next AR can be accepted at edge M+1, giving a one-cycle bubble between bursts.
- Under backpressure (`rvalid&&!rready`), `rid`/`rdata`/`rresp`/`rlast` hold stable.
- `reset` asserted mid-burst: the burst is abandoned, all outputs return to reset values the next cycle, and memory contents are preserved.
- len=0: a single beat with `rlast`=1.

## Configuration
- Macro `AXI_ROM_RANGE_CHECK_EN`.
- Defined:
  - A beat address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*8) returns `rdata`=0 with `rresp`=10 (SLVERR).
  - The check is evaluated per beat, and the burst still completes its full length.
- Undefined:
  - No check is made; the index wraps modulo MEM_WORDS and `rresp` is always 00.

## Test plan
- Preload `mem[i]`=64'hA000_0000_0000_0000+i for i=0..15, BASE_ADDR=0.
  - Stimulus: AR addr 0x10, len 7, size 3, WRAP, id 0x5.
  - Required: data words 2,3,4,5,6,7,0,1; `rlast` on beat 8 only; `rid`=0x5; `rresp`=00.
- INCR, addr 0x38, len 3, size 3.
  - Required: words 7,8,9,10, delivered on 4 consecutive cycles with `rready`=1.
  - Required: `arready` low for exactly 4 cycles after the AR handshake cycle.
- FIXED, addr 0x20, len 2.
  - Required: word 4 three times, `rlast` on the 3rd.
- Backpressure: `rready` pattern 1,0,0,1,0,1… on an INCR len 5 burst.
  - Required: outputs stable during stalled cycles and 6 beats in order.
- `reset` pulsed after 3 beats of a len 7 burst.
  - Required: `rvalid`=0 next cycle; `arready`=1 one cycle after reset deasserts.
  - Required: a new AR to 0x0 returns word 0 first.
- Address BASE_ADDR+MEM_WORDS*8, len 0.
  - With the macro defined: `rresp`=10, `rdata`=0.
  - Without the macro: `rresp`=00, `rdata`=`mem[0]`.
